// File: rtl/operand_loader.sv
// Collects (input, weight) pairs into two register banks and presents them as one frame; build with ORDER_SHUFFLE_EN to rotate slot order by a per-frame offset.
// Latency: the frame is on out_valid 1 cycle after its final beat; frame_err comes 1 cycle after the offending beat.
// Backpressure: in_ready drops while a frame is held; the banks clear 1 cycle after out_valid && out_ready.
module operand_loader #(
    parameter int INPUT_SIZE = 10,
    parameter int WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [WIDTH-1:0]            in_weight,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INPUT_SIZE*WIDTH-1:0] inputs_flat,
    output logic [INPUT_SIZE*WIDTH-1:0] weights_flat,
    output logic                        frame_err
`ifdef ORDER_SHUFFLE_EN
    ,
    input  logic [$clog2(INPUT_SIZE)-1:0] rand_offset
`endif
);

    localparam int OW = $clog2(INPUT_SIZE);
    localparam int CW = $clog2(INPUT_SIZE + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(INPUT_SIZE - 1);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] in_bank [INPUT_SIZE];
    logic [WIDTH-1:0] w_bank  [INPUT_SIZE];
    logic            accept;
    logic            at_last_slot;
    logic            complete;
    logic            release_frame;
    logic [OW-1:0]   slot_idx;

    assign accept        = in_valid && in_ready;
    assign at_last_slot  = (cnt == LAST_CNT);
    assign complete      = accept && (in_last || at_last_slot);
    assign release_frame = out_valid && out_ready;

`ifdef ORDER_SHUFFLE_EN
    localparam logic [OW:0] SIZE_X = (OW + 1)'(INPUT_SIZE);

    logic [OW-1:0] offset_q;
    logic [OW-1:0] offset_red;
    logic [OW-1:0] offset_use;
    logic [OW:0]   slot_sum;

    // Rotate the beat index by the frame offset; both operands are below
    // INPUT_SIZE so one conditional subtract replaces the modulo.
    always_comb begin
        offset_red = rand_offset;
        if ({1'b0, rand_offset} >= SIZE_X) begin
            offset_red = OW'({1'b0, rand_offset} - SIZE_X);
        end
        offset_use = (cnt == '0) ? offset_red : offset_q;
        slot_sum   = {1'b0, cnt[OW-1:0]} + {1'b0, offset_use};
        if (slot_sum >= SIZE_X) begin
            slot_sum = slot_sum - SIZE_X;
        end
        slot_idx = slot_sum[OW-1:0];
    end

    // Offset is captured on the first beat so it stays fixed for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
        end else if (accept && (cnt == '0)) begin
            offset_q <= offset_red;
        end
    end
`else
    // Without shuffling, beat n lands in slot n.
    always_comb begin
        slot_idx = cnt[OW-1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs: accept beats in LOAD, offer the frame in HOLD.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (complete) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Beat counter, banks and the length-violation pulse. Banks clear on
    // release so unwritten slots of a short frame contribute zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            frame_err <= 1'b0;
            for (int k = 0; k < INPUT_SIZE; k++) begin
                in_bank[k] <= '0;
                w_bank[k]  <= '0;
            end
        end else begin
            frame_err <= accept && at_last_slot && !in_last;
            if (release_frame) begin
                cnt <= '0;
                for (int k = 0; k < INPUT_SIZE; k++) begin
                    in_bank[k] <= '0;
                    w_bank[k]  <= '0;
                end
            end else if (accept) begin
                cnt               <= cnt + 1'b1;
                in_bank[slot_idx] <= in_data;
                w_bank[slot_idx]  <= in_weight;
            end
        end
    end

    // Flatten the banks; slot k occupies bits [k*WIDTH +: WIDTH].
    for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_flat
        assign inputs_flat[g*WIDTH +: WIDTH]  = in_bank[g];
        assign weights_flat[g*WIDTH +: WIDTH] = w_bank[g];
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: frame vectors from a table plus hand sequences for stall, reset and shuffle.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected banks come from a slot model fed by the applied stimulus; sums are hand-computed constants.
module tb_operand_loader;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  in_weight = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [FW-1:0] inputs_flat;
    logic [FW-1:0] weights_flat;
    logic          frame_err;
`ifdef ORDER_SHUFFLE_EN
    logic [$clog2(N)-1:0] rand_offset = '0;
`endif

    operand_loader #(.INPUT_SIZE(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_weight    (in_weight),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .inputs_flat  (inputs_flat),
        .weights_flat (weights_flat),
        .frame_err    (frame_err)
`ifdef ORDER_SHUFFLE_EN
        ,
        .rand_offset  (rand_offset)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] w;
        logic         last;
        logic         exp_ov;
        logic         exp_err;
        logic [63:0]  exp_sum;
    } vec_t;

    vec_t         tbl [23];
    logic [W-1:0] m_in [N];
    logic [W-1:0] m_w  [N];
    int           n_total = 0;
    int           n_pass  = 0;
    int           beat_n  = 0;
    int           m_off   = 0;
    logic [FW-1:0] zero_flat = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_vec(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [FW-1:0] model_flat(input logic sel_w);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[k*W +: W] = sel_w ? m_w[k] : m_in[k];
        return f;
    endfunction

    function automatic logic [63:0] wsum(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s += 64'(a[k*W +: W]) * 64'(b[k*W +: W]);
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_in[k] = '0;
            m_w[k]  = '0;
        end
        beat_n = 0;
    endtask

    // One accepted beat; the model writes slot (beat + offset) mod N.
    task automatic beat(input logic [W-1:0] d, input logic [W-1:0] w, input logic l);
        int slot;
        slot = (beat_n + m_off) % N;
        m_in[slot] = d;
        m_w[slot]  = w;
        beat_n++;
        in_valid = 1'b1;
        in_data  = d;
        in_weight = w;
        in_last  = l;
        chk("in_ready_load", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_frame(input string name, input logic [63:0] exp_sum);
        chk_vec({name, "_inputs"}, inputs_flat, model_flat(1'b0));
        chk_vec({name, "_weights"}, weights_flat, model_flat(1'b1));
        chk({name, "_sum"}, wsum(inputs_flat, weights_flat), exp_sum);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_in_ready"}, in_ready, 1);
        chk_vec({name, "_inputs_zero"}, inputs_flat, zero_flat);
        chk_vec({name, "_weights_zero"}, weights_flat, zero_flat);
    endtask

    initial begin
        // Full frame: data k+1, weight 2, last on beat 9.
        for (int k = 0; k < 10; k++) begin
            tbl[k].d = W'(k + 1); tbl[k].w = 16'd2; tbl[k].last = (k == 9);
            tbl[k].exp_ov = (k == 9); tbl[k].exp_err = 1'b0; tbl[k].exp_sum = 64'd110;
        end
        // Short frame of three pairs.
        tbl[10].d = 16'd5; tbl[10].w = 16'd3; tbl[10].last = 1'b0; tbl[10].exp_ov = 1'b0; tbl[10].exp_err = 1'b0; tbl[10].exp_sum = 64'd0;
        tbl[11].d = 16'd7; tbl[11].w = 16'd1; tbl[11].last = 1'b0; tbl[11].exp_ov = 1'b0; tbl[11].exp_err = 1'b0; tbl[11].exp_sum = 64'd0;
        tbl[12].d = 16'd2; tbl[12].w = 16'd4; tbl[12].last = 1'b1; tbl[12].exp_ov = 1'b1; tbl[12].exp_err = 1'b0; tbl[12].exp_sum = 64'd30;
        // Ten beats without in_last: data 10..19, weight 1.
        for (int k = 0; k < 10; k++) begin
            tbl[13+k].d = W'(k + 10); tbl[13+k].w = 16'd1; tbl[13+k].last = 1'b0;
            tbl[13+k].exp_ov = (k == 9); tbl[13+k].exp_err = (k == 9); tbl[13+k].exp_sum = 64'd145;
        end

        model_clear();
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk_vec("reset_inputs", inputs_flat, zero_flat);
        chk_vec("reset_weights", weights_flat, zero_flat);

        // Table frames with out_ready held high.
        for (int i = 0; i < 23; i++) begin
            beat(tbl[i].d, tbl[i].w, tbl[i].last);
            chk("tbl_out_valid", out_valid, 64'(tbl[i].exp_ov));
            chk("tbl_frame_err", frame_err, 64'(tbl[i].exp_err));
            if (tbl[i].exp_ov) begin
                chk("tbl_hold_in_ready", in_ready, 0);
                chk_frame("tbl_frame", tbl[i].exp_sum);
                step();
                chk_cleared("tbl_release");
                chk("tbl_err_one_cycle", frame_err, 0);
                model_clear();
            end
        end

        // Stall in HOLD for 20 cycles while in_valid toggles.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) beat(W'(3 * k + 1), W'(k + 2), k == 3);
        chk("stall_out_valid", out_valid, 1);
        for (int c = 0; c < 20; c++) begin
            in_valid  = c[0];
            in_data   = W'($urandom);
            in_weight = W'($urandom);
            in_last   = 1'b1;
            chk("stall_in_ready", in_ready, 0);
            step();
            chk("stall_out_valid_held", out_valid, 1);
            chk_vec("stall_inputs", inputs_flat, model_flat(1'b0));
            chk_vec("stall_weights", weights_flat, model_flat(1'b1));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        chk_cleared("stall_release");
        model_clear();

        // Reset after 4 of 10 beats, then a fresh full frame.
        for (int k = 0; k < 4; k++) beat(16'd9, 16'd9, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cleared("midrst");
        chk("midrst_frame_err", frame_err, 0);
        model_clear();
        for (int k = 0; k < 10; k++) beat(W'(100 + k), W'(k), k == 9);
        chk("midrst_fresh_out_valid", out_valid, 1);
        chk("midrst_fresh_frame_err", frame_err, 0);
        chk_frame("midrst_fresh", 64'd4785);
        step();
        chk_cleared("midrst_fresh_release");
        model_clear();

`ifdef ORDER_SHUFFLE_EN
        // Offset 7 sampled on beat 0 only; later values must be ignored.
        m_off = 7;
        for (int k = 0; k < 10; k++) begin
            rand_offset = (k == 0) ? 4'd7 : 4'd5;
            beat(W'(k), 16'd1, k == 9);
        end
        chk("shuf7_out_valid", out_valid, 1);
        chk("shuf7_slot0", 64'(inputs_flat[0 +: W]), 3);
        chk_frame("shuf7", 64'd45);
        step();
        chk_cleared("shuf7_release");
        model_clear();
        // Offset 12 reduces to 2.
        m_off = 2;
        for (int k = 0; k < 10; k++) begin
            rand_offset = (k == 0) ? 4'd12 : 4'd1;
            beat(W'(k), 16'd1, k == 9);
        end
        chk("shuf12_slot0", 64'(inputs_flat[0 +: W]), 8);
        chk_frame("shuf12", 64'd45);
        step();
        chk_cleared("shuf12_release");
        model_clear();
        m_off = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
